// File: rtl/buf_wr_arbiter_pkg.sv
// Shared types and constants for the buffer write arbiter and its round-robin picker.
package buf_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int BUF_ADDR_WIDTH = 3;
    localparam int CNT_WIDTH      = BUF_ADDR_WIDTH + 1;
    localparam int GRANT_WIDTH    = 3;

    // Round-robin successor of a grant index, wrapping at num_req.
    function automatic logic [GRANT_WIDTH-1:0] rr_next(input logic [GRANT_WIDTH-1:0] cur,
                                                       input int num_req);
        logic [GRANT_WIDTH-1:0] nxt;
        if (int'(cur) >= num_req - 1) begin
            nxt = {GRANT_WIDTH{1'b0}};
        end else begin
            nxt = cur + {{(GRANT_WIDTH-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/buf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping to 0.
module rr_pick
    import buf_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = GRANT_WIDTH
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_onehot,
    output logic [IDX_WIDTH-1:0] o_idx
);

    logic w_found;

    // Pass one scans ptr..top; pass two covers the wrapped range below ptr.
    always_comb begin
        o_onehot = {NUM_REQ{1'b0}};
        o_idx    = {IDX_WIDTH{1'b0}};
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_WIDTH'(i);
            end else begin
                w_found = w_found;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_WIDTH'(i);
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/buf_wr_arbiter.sv
// Round-robin burst write arbiter, occupancy counter and valid/ready read stream for a shared buffer.
// Define BUF_WR_ARBITER_BURST_LOCK_EN to hold the grant until req_last; otherwise every beat re-arbitrates.
module buf_wr_arbiter
    import buf_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [GRANT_WIDTH-1:0]        grant_id,
    output logic                          buf_wr,
    output logic [DATA_WIDTH-1:0]         buf_datain,
    output logic                          buf_rd,
    input  logic [DATA_WIDTH-1:0]         buf_dataout,
    input  logic                          buf_empty,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    input  logic                          m_ready,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          full
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [GRANT_WIDTH-1:0]  r_grant;
    logic [GRANT_WIDTH-1:0]  w_grant_nxt;
    logic [GRANT_WIDTH-1:0]  r_rr_ptr;
    logic [GRANT_WIDTH-1:0]  w_rr_ptr_nxt;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH:0]     w_count_nxt;
    logic                    r_full;
    logic [NUM_REQ-1:0]      w_pick_onehot;
    logic [GRANT_WIDTH-1:0]  w_pick_idx;
    logic                    w_g_valid;
    logic                    w_g_last;
    logic [DATA_WIDTH-1:0]   w_g_data;
    logic                    w_burst_end;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (GRANT_WIDTH)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

    // Granted requester's lane mux and ready; gating on r_full keeps ready independent of m_ready.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = {DATA_WIDTH{1'b0}};
        req_ready = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GRANT_WIDTH'(i)) begin
                w_g_valid    = req_valid[i];
                w_g_last     = req_last[i];
                w_g_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = (r_state == BURST) && !r_full;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    assign buf_wr     = (r_state == BURST) && w_g_valid && !r_full;
    assign buf_datain = w_g_data;

`ifdef BUF_WR_ARBITER_BURST_LOCK_EN
    assign w_burst_end = buf_wr && w_g_last;
`else
    logic w_last_unused;
    assign w_last_unused = w_g_last;
    assign w_burst_end   = buf_wr;
`endif

    assign m_valid = !buf_empty;
    assign m_data  = buf_dataout;
    assign buf_rd  = !buf_empty && m_ready;

    // Next-state: IDLE registers the round-robin pick, BURST releases on the ending beat.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if ((|w_pick_onehot) && !r_full) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick_idx;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BURST: begin
                if (w_burst_end) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = rr_next(r_grant, NUM_REQ);
                end else begin
                    w_state_nxt = BURST;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Occupancy update; a simultaneous write and read cancel.
    always_comb begin
        case ({buf_wr, buf_rd})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // State, grant, pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_grant  <= {GRANT_WIDTH{1'b0}};
            r_rr_ptr <= {GRANT_WIDTH{1'b0}};
            r_count  <= {(ADDR_WIDTH+1){1'b0}};
            r_full   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CNT_FULL);
        end
    end

    assign grant_id = r_grant;
    assign count    = r_count;
    assign full     = r_full;

endmodule

// File: tb/tb_buf_wr_arbiter.sv
// Directed self-checking bench for buf_wr_arbiter with a behavioural 8-entry buffer and requester models.
`timescale 1ns/1ps
module tb_buf_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;

`ifdef BUF_WR_ARBITER_BURST_LOCK_EN
    localparam int T1_GAP     = 1;
    localparam int EXP_T2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    localparam int EXP_T6 [8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    localparam int GAP_T6 [7]  = '{1, 1, 1, 2, 1, 1, 1};
`else
    localparam int T1_GAP     = 2;
    localparam int EXP_T2 [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
    localparam int EXP_T6 [8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
    localparam int GAP_T6 [7]  = '{2, 2, 2, 2, 2, 2, 2};
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [2:0]           grant_id;
    logic                 buf_wr;
    logic [DW-1:0]        buf_datain;
    logic                 buf_rd;
    logic [DW-1:0]        buf_dataout;
    logic                 buf_empty;
    logic                 m_valid;
    logic [DW-1:0]        m_data;
    logic                 m_ready;
    logic [3:0]           count;
    logic                 full;

    always #10 clk = ~clk;

    buf_wr_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .buf_wr      (buf_wr),
        .buf_datain  (buf_datain),
        .buf_rd      (buf_rd),
        .buf_dataout (buf_dataout),
        .buf_empty   (buf_empty),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .count       (count),
        .full        (full)
    );

    // Behavioural shared buffer: combinational read data, pointer-equality empty.
    logic [DW-1:0] mem [8];
    logic [3:0]    wp;
    logic [3:0]    rp;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= 4'd0;
            rp <= 4'd0;
        end else begin
            if (buf_wr) begin
                mem[wp[2:0]] <= buf_datain;
                wp           <= wp + 4'd1;
            end
            if (buf_rd) rp <= rp + 4'd1;
        end
    end
    assign buf_dataout = mem[rp[2:0]];
    assign buf_empty   = (wp == rp);

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int onehot_bad = 0;
    int inv_bad    = 0;

    logic [DW-1:0] bdata [NREQ][16];
    logic          blast [NREQ][16];
    int            bn    [NREQ];
    int            bix   [NREQ];

    int            wlog_id  [$];
    logic [DW-1:0] wlog_dat [$];
    int            wlog_cyc [$];
    logic [DW-1:0] rlog     [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int r, input int b);
        return {8'hD0, 40'h0, r[7:0], b[7:0]};
    endfunction

    task automatic load(input int r, input int n, input int burst);
        bn[r]  = n;
        bix[r] = 0;
        for (int b = 0; b < n; b++) begin
            bdata[r][b] = mk(r, b + 1);
            blast[r][b] = (((b + 1) % burst) == 0);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (bix[i] < bn[i]) begin
                req_valid[i]            = 1'b1;
                req_last[i]             = blast[i][bix[i]];
                req_data[i*DW +: DW]    = bdata[i][bix[i]];
            end else begin
                req_valid[i]            = 1'b0;
                req_last[i]             = 1'b0;
                req_data[i*DW +: DW]    = {DW{1'b0}};
            end
        end
    endtask

    // One clock: sample and log at the falling edge, advance requesters just after the rising edge.
    task automatic cycle();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if ($countones(req_ready) > 1) onehot_bad++;
        if ((count == 4'd0) != buf_empty) inv_bad++;
        if (buf_wr) begin
            wlog_id.push_back(int'(grant_id));
            wlog_dat.push_back(buf_datain);
            wlog_cyc.push_back(cyc);
        end
        if (buf_rd) rlog.push_back(m_data);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (hs[i]) bix[i]++;
        drive_reqs();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bn[i]  = 0;
            bix[i] = 0;
        end
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        wlog_id.delete();
        wlog_dat.delete();
        wlog_cyc.delete();
        rlog.delete();
    endtask

    task automatic check_stream(input string tag, input int r, input int n);
        check({tag, "_rcount"}, rlog.size(), n);
        for (int k = 0; k < n; k++)
            check({tag, "_rdata"}, (k < rlog.size()) ? rlog[k] : 64'hBAD, mk(r, k + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int occ [NREQ];
        reset_n = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bn[i]  = 0;
            bix[i] = 0;
        end
        load(0, 2, 2);
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_ready", req_ready, 0);
        check("rst_wr", buf_wr, 0);
        check("rst_rd", buf_rd, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_grant", grant_id, 0);

        // Single burst from requester 0.
        do_reset();
        load(0, 3, 3);
        drive_reqs();
        #1;
        check("t1_ready_first", req_ready, 4'b0000);
        cycle();
        check("t1_ready_next", req_ready, 4'b0001);
        check("t1_grant", grant_id, 0);
        for (int k = 0; k < 40 && bix[0] < 3; k++) cycle();
        check("t1_beats", bix[0], 3);
        check("t1_count", count, 3);
        check("t1_idle_ready", req_ready, 4'b0000);
        check("t1_gap", (wlog_cyc.size() >= 3) ? (wlog_cyc[2] - wlog_cyc[1]) : -1, T1_GAP);
        m_ready = 1'b1;
        for (int k = 0; k < 20 && m_valid; k++) cycle();
        check("t1_drained", count, 0);
        check("t1_mvalid", m_valid, 0);
        check_stream("t1", 0, 3);

        // Contention between all four requesters, two-beat bursts.
        do_reset();
        onehot_bad = 0;
        m_ready    = 1'b1;
        load(0, 4, 2);
        load(1, 2, 2);
        load(2, 2, 2);
        load(3, 2, 2);
        drive_reqs();
        for (int k = 0; k < 80 && (bix[0] < 4 || bix[1] < 2 || bix[2] < 2 || bix[3] < 2 || m_valid); k++)
            cycle();
        check("t2_wcount", wlog_id.size(), 10);
        for (int i = 0; i < NREQ; i++) occ[i] = 0;
        for (int k = 0; k < 10; k++) begin
            occ[EXP_T2[k]]++;
            check("t2_grant", (k < wlog_id.size()) ? wlog_id[k] : -1, EXP_T2[k]);
            check("t2_rdata", (k < rlog.size()) ? rlog[k] : 64'hBAD, mk(EXP_T2[k], occ[EXP_T2[k]]));
        end
        check("t2_onehot", onehot_bad, 0);

        // Full back-pressure with requester 2 sending ten beats.
        do_reset();
        load(2, 10, 10);
        drive_reqs();
        for (int k = 0; k < 40 && count != 4'd8; k++) cycle();
        check("t3_count8", count, 8);
        check("t3_full", full, 1);
        check("t3_ready0", req_ready, 4'b0000);
        check("t3_beats8", bix[2], 8);
        repeat (3) cycle();
        check("t3_hold_count", count, 8);
        check("t3_hold_beats", bix[2], 8);
        m_ready = 1'b1;
        #1;
        check("t3_pulse_rd", buf_rd, 1);
        check("t3_pulse_data", m_data, mk(2, 1));
        cycle();
        m_ready = 1'b0;
        #1;
        check("t3_count7", count, 7);
        check("t3_notfull", full, 0);
`ifdef BUF_WR_ARBITER_BURST_LOCK_EN
        check("t3_ready9", req_ready, 4'b0100);
        cycle();
`else
        check("t3_rearb", req_ready, 4'b0000);
        cycle();
        check("t3_ready9", req_ready, 4'b0100);
        cycle();
`endif
        check("t3_beat9", bix[2], 9);
        check("t3_refull", count, 8);
        rlog.delete();
        rlog.push_back(mk(2, 1));
        m_ready = 1'b1;
        for (int k = 0; k < 60 && (bix[2] < 10 || m_valid); k++) cycle();
        check_stream("t3", 2, 10);

        // Simultaneous write and read at count 4.
        do_reset();
        load(3, 6, 6);
        drive_reqs();
        for (int k = 0; k < 40 && !(count == 4'd4 && buf_wr); k++) cycle();
        check("t4_count4", count, 4);
        check("t4_wr", buf_wr, 1);
        m_ready = 1'b1;
        #1;
        check("t4_rd", buf_rd, 1);
        cycle();
        m_ready = 1'b0;
        #1;
        check("t4_count_same", count, 4);
        m_ready = 1'b1;
        for (int k = 0; k < 60 && (bix[3] < 6 || m_valid); k++) cycle();
        check_stream("t4", 3, 6);

        // Reset in the middle of requester 2's burst.
        do_reset();
        load(1, 1, 1);
        load(2, 4, 4);
        drive_reqs();
        for (int k = 0; k < 40 && bix[2] < 2; k++) cycle();
        check("t5_pre_grant", grant_id, 2);
        check("t5_pre_count", count, 3);
        reset_n = 1'b0;
        #1;
        check("t5_count", count, 0);
        check("t5_full", full, 0);
        check("t5_mvalid", m_valid, 0);
        check("t5_ready", req_ready, 4'b0000);
        check("t5_wr", buf_wr, 0);
        check("t5_grant", grant_id, 0);
        repeat (2) @(posedge clk);
        #1;
        bn[2] = 0;
        load(1, 2, 2);
        load(3, 2, 2);
        drive_reqs();
        reset_n = 1'b1;
        #1;
        check("t5_rel_ready", req_ready, 4'b0000);
        cycle();
        check("t5_fresh_grant", grant_id, 1);
        check("t5_fresh_ready", req_ready, 4'b0010);

        // Requesters 0 and 1 each hold valid for four beats.
        do_reset();
        m_ready = 1'b1;
        load(0, 4, 4);
        load(1, 4, 4);
        drive_reqs();
        for (int k = 0; k < 60 && (bix[0] < 4 || bix[1] < 4); k++) cycle();
        check("t6_wcount", wlog_id.size(), 8);
        for (int k = 0; k < 8; k++)
            check("t6_order", (k < wlog_id.size()) ? wlog_id[k] : -1, EXP_T6[k]);
        for (int k = 0; k < 7; k++)
            check("t6_gap", (k + 1 < wlog_cyc.size()) ? (wlog_cyc[k+1] - wlog_cyc[k]) : -1, GAP_T6[k]);

        check("inv_count_empty", inv_bad, 0);
        check("onehot_total", onehot_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
